// File: rtl/mux4_rr_arbiter_if.sv
// Bundle of the request/data inputs and grant/select outputs shared between
// the requesters and the round-robin mux arbiter.
interface mux4_rr_arbiter_if #(
  parameter int CNT_W = 4
) ();
  logic [3:0]       req;
  logic [3:0]       din;
  logic [3:0]       gnt;
  logic [1:0]       sel;
  logic             dout;
  logic             busy;
  logic [CNT_W-1:0] hold_cnt;

  modport master (
    output req, din,
    input  gnt, sel, dout, busy, hold_cnt
  );

  modport slave (
    input  req, din,
    output gnt, sel, dout, busy, hold_cnt
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin select sequencer for a shared 4:1 single-bit mux; grants are
// bounded to HOLD_MAX consecutive cycles, then re-arbitrated.
//
// state   | meaning
// S_IDLE  | no grant active, waiting for any req
// S_GRANT | one requester owns the mux path, hold counter running
module mux4_rr_arbiter #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input logic              clk,
  input logic              rst_n,
  mux4_rr_arbiter_if.slave bus
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             busy_q, busy_d;

  logic [1:0] ptr;
  logic [1:0] idx;
  logic [1:0] winner;
  logic       found;
  logic       release_grant;

  // On a release the outgoing owner becomes the new pointer in the same cycle,
  // so the search starts from sel rather than the not-yet-updated last.
  always_comb begin
    ptr    = (state_q == S_GRANT) ? sel_q : last_q;
    idx    = ptr;
    winner = ptr;
    found  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && bus.req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign release_grant = (state_q == S_GRANT) &&
                         (!bus.req[sel_q] || (hold_q == CNT_W'(HOLD_MAX)));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    hold_d  = hold_q;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_GRANT;
          gnt_d   = 4'b0001 << winner;
          sel_d   = winner;
          hold_d  = CNT_W'(1);
          busy_d  = 1'b1;
        end
      end
      S_GRANT: begin
        if (!release_grant) begin
          hold_d = hold_q + CNT_W'(1);
        end else begin
          last_d = sel_q;
          if (found) begin
            gnt_d  = 4'b0001 << winner;
            sel_d  = winner;
            hold_d = CNT_W'(1);
          end else begin
            state_d = S_IDLE;
            gnt_d   = 4'b0000;
            hold_d  = '0;
            busy_d  = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
      last_q  <= 2'b11;
      hold_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.sel      = sel_q;
  assign bus.busy     = busy_q;
  assign bus.hold_cnt = hold_q;
  assign bus.dout     = busy_q ? bus.din[sel_q] : 1'b0;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: two instances (HOLD_MAX 8 and 2) on shared
// stimulus, compared every cycle against an owner/counter reference model.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] din = 4'b0000;

  int n_assert = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  mux4_rr_arbiter_if #(.CNT_W(4)) if8 ();
  mux4_rr_arbiter_if #(.CNT_W(4)) if2 ();

  assign if8.req = req;
  assign if8.din = din;
  assign if2.req = req;
  assign if2.din = din;

  mux4_rr_arbiter #(.HOLD_MAX(8), .CNT_W(4)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  mux4_rr_arbiter #(.HOLD_MAX(2), .CNT_W(4)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  logic [3:0] d_gnt  [2];
  logic [1:0] d_sel  [2];
  logic       d_busy [2];
  logic       d_dout [2];
  logic [3:0] d_hold [2];

  assign d_gnt[0] = if8.gnt;  assign d_gnt[1] = if2.gnt;
  assign d_sel[0] = if8.sel;  assign d_sel[1] = if2.sel;
  assign d_busy[0] = if8.busy; assign d_busy[1] = if2.busy;
  assign d_dout[0] = if8.dout; assign d_dout[1] = if2.dout;
  assign d_hold[0] = if8.hold_cnt; assign d_hold[1] = if2.hold_cnt;

  // Reference model: owner index (-1 when idle), cycles owned, pointer, select.
  int hold_max [2] = '{8, 2};
  int m_owner  [2] = '{-1, -1};
  int m_cnt    [2] = '{0, 0};
  int m_last   [2] = '{3, 3};
  int m_sel    [2] = '{0, 0};

  function automatic int pick(input logic [3:0] r, input int from);
    for (int k = 1; k <= 4; k++)
      if (r[(from + k) % 4]) return (from + k) % 4;
    return -1;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_owner[i] = -1; m_cnt[i] = 0; m_last[i] = 3; m_sel[i] = 0;
      end else if (m_owner[i] < 0) begin
        if (req != 4'b0000) begin
          m_owner[i] = pick(req, m_last[i]); m_sel[i] = m_owner[i]; m_cnt[i] = 1;
        end
      end else if (!req[m_owner[i]] || m_cnt[i] == hold_max[i]) begin
        m_last[i]  = m_owner[i];
        m_owner[i] = pick(req, m_last[i]);
        if (m_owner[i] >= 0) begin
          m_sel[i] = m_owner[i]; m_cnt[i] = 1;
        end else begin
          m_cnt[i] = 0;
        end
      end else begin
        m_cnt[i] = m_cnt[i] + 1;
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    n_assert++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      for (int i = 0; i < 2; i++) begin
        int exp_gnt;
        int exp_busy;
        exp_gnt  = (m_owner[i] < 0) ? 0 : (1 << m_owner[i]);
        exp_busy = (m_owner[i] < 0) ? 0 : 1;
        check(i == 0 ? "h8.gnt" : "h2.gnt", int'(d_gnt[i]), exp_gnt);
        check(i == 0 ? "h8.sel" : "h2.sel", int'(d_sel[i]), m_sel[i]);
        check(i == 0 ? "h8.busy" : "h2.busy", int'(d_busy[i]), exp_busy);
        check(i == 0 ? "h8.hold" : "h2.hold", int'(d_hold[i]), m_cnt[i]);
        check(i == 0 ? "h8.dout" : "h2.dout", int'(d_dout[i]),
              exp_busy ? int'(din[m_sel[i]]) : 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset with all requests high
    rst_n = 1'b0; req = 4'b1111; din = 4'b0000;
    tick();
    check_en = 1'b1;
    tick();
    check("rst.gnt", int'(if8.gnt), 0);
    check("rst.busy", int'(if8.busy), 0);
    check("rst.dout", int'(if8.dout), 0);
    check("rst.hold", int'(if8.hold_cnt), 0);
    rst_n = 1'b1;
    tick();
    check("first.gnt", int'(if8.gnt), 4'b0001);
    check("first.sel", int'(if8.sel), 0);

    // Single requester burst
    req = 4'b0100; din = 4'b0100;
    tick();
    check("burst.gnt", int'(if8.gnt), 4'b0100);
    check("burst.hold1", int'(if8.hold_cnt), 1);
    check("burst.dout", int'(if8.dout), 1);
    repeat (7) tick();
    check("burst.hold8", int'(if8.hold_cnt), 8);
    tick();
    check("burst.regrant.gnt", int'(if8.gnt), 4'b0100);
    check("burst.regrant.hold", int'(if8.hold_cnt), 1);

    // Fair rotation on the HOLD_MAX=2 instance
    rst_n = 1'b0; tick();
    rst_n = 1'b1; req = 4'b1111;
    tick();
    for (int i = 0; i < 9; i++) begin
      check("rot.gnt", int'(if2.gnt), 1 << ((i / 2) % 4));
      check("rot.busy", int'(if2.busy), 1);
      tick();
    end

    // Early release
    rst_n = 1'b0; tick();
    rst_n = 1'b1; req = 4'b0010;
    tick();
    check("early.gnt1", int'(if8.gnt), 4'b0010);
    tick(); tick();
    check("early.hold3", int'(if8.hold_cnt), 3);
    req = 4'b1001;
    tick();
    check("early.gnt", int'(if8.gnt), 4'b1000);
    check("early.sel", int'(if8.sel), 3);
    check("early.hold", int'(if8.hold_cnt), 1);

    // Idle return and re-raise
    req = 4'b0100; din = 4'b0100;
    tick();
    check("idle.gnt2", int'(if8.gnt), 4'b0100);
    req = 4'b0000;
    tick();
    check("idle.gnt", int'(if8.gnt), 0);
    check("idle.busy", int'(if8.busy), 0);
    check("idle.dout", int'(if8.dout), 0);
    check("idle.sel", int'(if8.sel), 2);
    req = 4'b0001;
    tick();
    check("reraise.gnt", int'(if8.gnt), 4'b0001);

    // Reset mid-grant
    req = 4'b0010;
    tick();
    repeat (4) tick();
    check("midrst.pre.gnt", int'(if8.gnt), 4'b0010);
    check("midrst.pre.hold", int'(if8.hold_cnt), 5);
    rst_n = 1'b0;
    tick();
    check("midrst.gnt", int'(if8.gnt), 0);
    rst_n = 1'b1; req = 4'b1111;
    tick();
    check("midrst.after", int'(if8.gnt), 4'b0001);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      din   = 4'($urandom);
      rst_n = ($urandom_range(0, 99) != 0);
      tick();
    end

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
